pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Supervises the video/core PLL from the 50 MHz reference domain: drives the PLL's `rst` input, watches its `locked` output, and produces a clean, debounced core reset. It sits between the PLL wrapper and the core. It re-resets the PLL on lock timeout or loss of lock, and it reports a sticky failure after repeated unsuccessful lock attempts.

## Interface
Parameters:
- `RST_CYCLES`, 16: number of cycles `pll_rst` is held high per PLL reset attempt (≥1).
- `LOCK_TIMEOUT`, 500000: cycles allowed in WAIT_LOCK before an attempt is declared failed (10 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-high `locked` samples required before releasing the core.
- `MAX_RETRIES`, 7: consecutive timed-out attempts after which the block enters FAIL (≥1).

Ports:
- `refclk`, in, 1: 50 MHz reference clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `locked`, in, 1: PLL lock flag, asynchronous to `refclk`.
- `relock_req`, in, 1: single-cycle request to re-lock the PLL; honoured only in RUN.
- `pll_rst`, out, 1: reset to the PLL.
- `core_reset`, out, 1: core reset, active-high.
- `ready`, out, 1: high exactly when in RUN.
- `fail`, out, 1: sticky failure flag, cleared only by `rst`.
- `loss_count`, out, 8: count of lock losses while in RUN; saturates at 255.

## Operation
- `locked` passes through a 2-FF synchronizer to form `locked_s`; this adds 2 cycles of latency. All decisions use `locked_s`.
- States are RESET_PLL, WAIT_LOCK, DEBOUNCE, RUN and FAIL.
- RESET_PLL: `pll_rst`=1. After `RST_CYCLES` cycles, go to WAIT_LOCK. The cycle counter is cleared on entry to every state.
- WAIT_LOCK:
  - If `locked_s`=1, go to DEBOUNCE.
  - If `LOCK_TIMEOUT` cycles elapse with `locked_s`=0, increment `retries`. If `retries` now equals `MAX_RETRIES`, go to FAIL; otherwise go to RESET_PLL.
- DEBOUNCE:
  - Any `locked_s`=0 sample returns to WAIT_LOCK with a fresh timeout. `retries` is not incremented.
  - `STABLE_CYCLES` consecutive high samples go to RUN and clear `retries`.
- RUN: `core_reset`=0 and `ready`=1.
  - `locked_s`=0 goes to RESET_PLL and saturating-increments `loss_count`.
  - `relock_req`=1 with `locked_s`=1 goes to RESET_PLL without changing `loss_count`.
  - If both events occur in the same cycle, it counts as a loss.
- FAIL: `pll_rst`=1, `core_reset`=1, `fail`=1. This is terminal until `rst`.
- `relock_req` is ignored in every state except RUN.
- `core_reset`=1 in every state except RUN.
- `pll_rst`=1 only in RESET_PLL and FAIL.

## Timing
- All outputs are registered and decoded from the state register.
- Reset values:
  - State is RESET_PLL with counter 0 and `retries`=0.
  - `pll_rst`=1, `core_reset`=1, `ready`=0, `fail`=0, `loss_count`=0.
  - Synchronizer flops are 0.
- `rst` asserted mid-operation, in any state, returns to the reset values on the next edge. `loss_count` and `fail` are cleared.
- Counting starts from the first cycle with `rst` low. `pll_rst` stays high for exactly `RST_CYCLES` cycles and falls in the first WAIT_LOCK cycle.
- Minimum delay from a `locked` rise to `core_reset` falling is 2 + 1 + `STABLE_CYCLES` cycles. This covers synchronization, the WAIT_LOCK→DEBOUNCE edge, and debounce.
- Loss of lock in RUN: `core_reset` rises 1 cycle after `locked_s` falls, which is 3 cycles after `locked` falls. `pll_rst` rises in the same cycle.
- Counter widths are `$clog2` of the largest of the three cycle parameters. `retries` width is `$clog2(MAX_RETRIES+1)`.
- Counters never wrap. Each state exits when its counter reaches its limit minus 1.

## Structure
- A shared package `pll_sup_pkg` holds:
  - the state enum `pll_sup_state_t`;
  - the `LOSS_CNT_W`=8 constant;
  - the default parameter constants.
- One sub-module, `sync_2ff`, provides the generic 2-FF synchronizer with its reset value as a parameter. It is reusable by other cross-domain inputs.
- The state machine and counters live in `pll_lock_supervisor` itself.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- **Clean lock:** release `rst` at cycle 0; `locked` rises at cycle 6 and stays high. Expect `pll_rst` high for cycles 0–3; `core_reset` falls and `ready` rises at cycle 17 (6+2+1+8); `fail`=0.
- **Glitchy lock:** `locked` high for 5 cycles, low for 1, then steady. Expect a return to WAIT_LOCK with no retry counted; `ready` goes high 11 cycles after the final rise; no second `pll_rst` pulse.
- **Timeout to FAIL:** hold `locked`=0. Expect two `pll_rst` pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles; after the second timeout `fail`=1, `pll_rst`=1, `core_reset`=1; later `locked`=1 changes nothing until `rst`.
- **Loss in RUN:** drop `locked` for 1 cycle while `ready`=1. Expect `core_reset`=1 and `pll_rst`=1 exactly 3 cycles later, `loss_count` 0→1, and the full re-lock sequence to follow. Repeat 300 times and expect `loss_count`=255.
- **Relock and simultaneity:**
  - Pulse `relock_req` in RUN: expect RESET_PLL and `loss_count` unchanged.
  - Pulse `relock_req` in DEBOUNCE: expect it to be ignored.
  - Pulse `relock_req` in the same cycle as `locked_s` falls: expect `loss_count`+1.
- **Mid-operation reset:** assert `rst` for 1 cycle during DEBOUNCE with `loss_count`=3. Expect all reset values on the next edge, including `loss_count`=0, then the sequence restarts with `pll_rst` high for 4 cycles.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// Holds the supervisor state enum, the loss counter width and parameter defaults.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_DEBOUNCE,
        ST_RUN,
        ST_FAIL
    } pll_sup_state_t;

    localparam int LOSS_CNT_W = 8;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 500000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single-bit asynchronous input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, debounces its lock flag and produces the core reset.
// Ports: refclk, rst (sync, active-high), locked (async), relock_req ->
//        pll_rst, core_reset, ready, fail (sticky), loss_count (saturating).
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  core_reset,
    output logic                  ready,
    output logic                  fail,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [LOSS_CNT_W-1:0] LOSS_SAT = '1;

    pll_sup_state_t        state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [RTY_W-1:0]      retries, retries_nxt, rty_inc;
    logic [LOSS_CNT_W-1:0] loss_q, loss_nxt;
    logic                  locked_s;

    sync_2ff #(
        .RESET_VAL(1'b0)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (locked),
        .q  (locked_s)
    );

    assign rty_inc = retries + RTY_W'(1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        retries_nxt = retries;
        loss_nxt    = loss_q;
        unique case (state)
            ST_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = ST_DEBOUNCE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_nxt     = '0;
                    retries_nxt = rty_inc;
                    state_nxt   = (rty_inc == RTY_MAX) ? ST_FAIL
                                                       : ST_RESET_PLL;
                end
            end
            ST_DEBOUNCE: begin
                // A single low sample restarts the lock wait, no retry charged.
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STB_LAST) begin
                    state_nxt   = ST_RUN;
                    cnt_nxt     = '0;
                    retries_nxt = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                // Loss of lock wins over a simultaneous relock request.
                if (!locked_s) begin
                    state_nxt = ST_RESET_PLL;
                    if (loss_q != LOSS_SAT) begin
                        loss_nxt = loss_q + LOSS_CNT_W'(1);
                    end
                end else if (relock_req) begin
                    state_nxt = ST_RESET_PLL;
                end
            end
            ST_FAIL: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = ST_RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state   <= ST_RESET_PLL;
            cnt     <= '0;
            retries <= '0;
            loss_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            retries <= retries_nxt;
            loss_q  <= loss_nxt;
        end
    end

    assign pll_rst    = (state == ST_RESET_PLL) || (state == ST_FAIL);
    assign core_reset = (state != ST_RUN);
    assign ready      = (state == ST_RUN);
    assign fail       = (state == ST_FAIL);
    assign loss_count = loss_q;

endmodule
